// File: rtl/axi_ram_rd_arbiter_if.sv
// Bus bundle for axi_ram_rd_arbiter: per-requester AR/R slave side plus the
// single AR/R master port toward the on-chip AXI RAM.
// slave modport is the arbiter's view; master modport is the environment's view.
interface axi_ram_rd_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8
);
    // Requester side, requester k occupies slice k of the packed vectors
    logic [NUM_REQ*ID_WIDTH-1:0]   s_arid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr;
    logic [NUM_REQ*8-1:0]          s_arlen;
    logic [NUM_REQ-1:0]            s_arvalid;
    logic [NUM_REQ-1:0]            s_arready;
    logic [DATA_WIDTH-1:0]         s_rdata;
    logic                          s_rlast;
    logic [NUM_REQ-1:0]            s_rvalid;
    logic [NUM_REQ-1:0]            s_rready;

    // RAM side
    logic [ID_WIDTH-1:0]           m_arid;
    logic [ADDR_WIDTH-1:0]         m_araddr;
    logic [7:0]                    m_arlen;
    logic [2:0]                    m_arsize;
    logic [1:0]                    m_arburst;
    logic                          m_arvalid;
    logic                          m_arready;
    logic [DATA_WIDTH-1:0]         m_rdata;
    logic                          m_rlast;
    logic                          m_rvalid;
    logic                          m_rready;

    modport slave (
        input  s_arid, s_araddr, s_arlen, s_arvalid, s_rready,
        input  m_arready, m_rdata, m_rlast, m_rvalid,
        output s_arready, s_rdata, s_rlast, s_rvalid,
        output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
    );

    modport master (
        output s_arid, s_araddr, s_arlen, s_arvalid, s_rready,
        output m_arready, m_rdata, m_rlast, m_rvalid,
        input  s_arready, s_rdata, s_rlast, s_rvalid,
        input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
    );
endinterface

// File: rtl/axi_ram_rd_arbiter.sv
// N-requester AXI4 read arbiter in front of the on-chip AXI RAM.
// Grants one whole burst at a time, keeps a single burst outstanding, routes
// R beats back to the granted requester and flags beat-count/ARLEN mismatch.
// Optional macro AXI_RD_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of the default round-robin.
module axi_ram_rd_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_ram_rd_arbiter_if.slave  bus,
    output logic                 len_err
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                r_state;
    logic [GW-1:0]         r_grant;
    logic [7:0]            r_beat_cnt;
    logic                  r_len_err;
    logic                  r_arvalid;
    logic [ID_WIDTH-1:0]   r_arid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_arlen;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
    logic [GW-1:0]         r_rr_ptr;
`endif

    logic                  w_gnt_found;
    logic [GW-1:0]         w_gnt_idx;
    logic                  w_m_rready;
    logic                  w_beat;

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    // Fixed-priority pick: scan high to low so the lowest requesting index wins
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.s_arvalid[i]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = GW'(i);
            end
        end
    end
`else
    // Round-robin pick starting after r_rr_ptr; descending offsets so the
    // nearest requester after the pointer is the last (winning) assignment
    always_comb begin
        int v_cand;
        v_cand      = 0;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            v_cand = (int'(r_rr_ptr) + off) % NUM_REQ;
            if (bus.s_arvalid[v_cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = GW'(v_cand);
            end
        end
    end
`endif

    // AR ready toward the chosen requester only in IDLE; R valid toward the grantee only in DATA
    always_comb begin
        bus.s_arready = '0;
        bus.s_rvalid  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if ((r_state == IDLE) && w_gnt_found && (w_gnt_idx == GW'(k))) begin
                bus.s_arready[k] = 1'b1;
            end
            if ((r_state == DATA) && (r_grant == GW'(k))) begin
                bus.s_rvalid[k] = bus.m_rvalid;
            end
        end
    end

    assign w_m_rready    = (r_state == DATA) && bus.s_rready[r_grant];
    assign w_beat        = bus.m_rvalid && w_m_rready;

    assign bus.m_rready  = w_m_rready;
    assign bus.s_rdata   = bus.m_rdata;
    assign bus.s_rlast   = bus.m_rlast;
    assign bus.m_arid    = r_arid;
    assign bus.m_araddr  = r_araddr;
    assign bus.m_arlen   = r_arlen;
    assign bus.m_arvalid = r_arvalid;
    assign bus.m_arsize  = 3'($clog2(STRB_WIDTH));
    assign bus.m_arburst = 2'b01;
    assign len_err       = r_len_err;

    // Burst FSM: latch the granted AR, present it to the RAM, then count R beats
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_beat_cnt <= '0;
            r_len_err  <= 1'b0;
            r_arvalid  <= 1'b0;
            r_arid     <= '0;
            r_araddr   <= '0;
            r_arlen    <= '0;
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
            r_rr_ptr   <= GW'(NUM_REQ - 1);
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_gnt_found) begin
                        r_grant    <= w_gnt_idx;
                        r_arid     <= bus.s_arid[w_gnt_idx*ID_WIDTH +: ID_WIDTH];
                        r_araddr   <= bus.s_araddr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        r_arlen    <= bus.s_arlen[w_gnt_idx*8 +: 8];
                        r_beat_cnt <= '0;
                        r_arvalid  <= 1'b1;
                        r_state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.m_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (bus.m_rlast) begin
                            // Count excludes the last beat, so it must equal ARLEN here
                            if (r_beat_cnt != r_arlen) begin
                                r_len_err <= 1'b1;
                            end
`ifndef AXI_RD_ARB_FIXED_PRIO_EN
                            r_rr_ptr <= r_grant;
`endif
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_rd_arbiter.sv
// Self-checking bench for axi_ram_rd_arbiter with a behavioural RAM slave,
// requester drivers and a burst-level reference model.
// Honours AXI_RD_ARB_FIXED_PRIO_EN for the expected arbitration order.
module tb_axi_ram_rd_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DW      = 32;
    localparam int AW      = 16;
    localparam int IW      = 8;
    localparam int MEMW    = 1024;

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } req_t;

    typedef struct {
        int          dest;
        logic [DW-1:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic len_err;

    always #5 clk = ~clk;

    axi_ram_rd_arbiter_if #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)
    ) bus ();

    axi_ram_rd_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .len_err(len_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem [MEMW];
    req_t          req_q [NUM_REQ][$];
    beat_t         exp_q [$];
    int            grant_log [$];
    int            stall_cnt [NUM_REQ];
    int            inj_tot = 0;
    bit            rr_rand = 1'b0;

    // Reference model state
    bit            m_busy = 1'b0;
    int            m_last = NUM_REQ - 1;
    bit            err_exp = 1'b0;
    bit            ar_pend = 1'b0;
    logic [IW-1:0] ar_id;
    logic [AW-1:0] ar_addr;
    logic [7:0]    ar_len;
    int            delivered = 0;
    logic [DW-1:0] last_data;
    logic          last_rlast;
    int            last_dest;

    // Which requester the arbitration rule picks from a set of requests
    function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
`else
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (v[(last + off) % NUM_REQ]) return (last + off) % NUM_REQ;
        end
`endif
        return -1;
    endfunction

    // Requesters: hold AR until accepted, then move on to the next queued request
    initial begin : req_drv
        bit ar_done [NUM_REQ];
        bus.s_arvalid = '0;
        bus.s_arid    = '0;
        bus.s_araddr  = '0;
        bus.s_arlen   = '0;
        bus.s_rready  = '0;
        for (int k = 0; k < NUM_REQ; k++) ar_done[k] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (ar_done[k] && req_q[k].size() > 0) void'(req_q[k].pop_front());
                ar_done[k] = 1'b0;
                if (req_q[k].size() > 0) begin
                    bus.s_arvalid[k]          = 1'b1;
                    bus.s_arid[k*IW +: IW]    = req_q[k][0].id;
                    bus.s_araddr[k*AW +: AW]  = req_q[k][0].addr;
                    bus.s_arlen[k*8 +: 8]     = req_q[k][0].len;
                end else begin
                    bus.s_arvalid[k] = 1'b0;
                end
                if (stall_cnt[k] > 0) begin
                    bus.s_rready[k] = 1'b0;
                    stall_cnt[k]--;
                end else begin
                    bus.s_rready[k] = rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
            end
            #1;
            for (int k = 0; k < NUM_REQ; k++) begin
                ar_done[k] = !rst && bus.s_arvalid[k] && bus.s_arready[k];
            end
        end
    end

    // RAM slave: random AR acceptance, random R gaps, data held while stalled
    initial begin : ram
        bit busy, taken;
        int base, tot, bi;
        busy = 1'b0; taken = 1'b0; base = 0; tot = 0; bi = 0;
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rlast   = 1'b0;
        bus.m_rdata   = '0;
        forever begin
            @(negedge clk);
            if (!busy) begin
                bus.m_rvalid  = 1'b0;
                bus.m_rlast   = 1'b0;
                bus.m_arready = ($urandom_range(0, 2) != 0);
            end else begin
                bus.m_arready = 1'b0;
                if (!bus.m_rvalid || taken) begin
                    taken = 1'b0;
                    if (bi < tot && $urandom_range(0, 3) != 0) begin
                        bus.m_rvalid = 1'b1;
                        bus.m_rdata  = mem[(base + bi) % MEMW];
                        bus.m_rlast  = (bi == tot - 1);
                    end else begin
                        bus.m_rvalid = 1'b0;
                        bus.m_rlast  = 1'b0;
                    end
                end
            end
            #1;
            if (rst) begin
                busy = 1'b0; taken = 1'b0;
                bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.m_arready = 1'b0;
            end else if (!busy) begin
                if (bus.m_arvalid && bus.m_arready) begin
                    busy  = 1'b1;
                    taken = 1'b0;
                    base  = int'(bus.m_araddr) >> 2;
                    tot   = (inj_tot > 0) ? inj_tot : int'(bus.m_arlen) + 1;
                    bi    = 0;
                end
            end else if (bus.m_rvalid && bus.m_rready) begin
                taken = 1'b1;
                bi++;
                if (bi == tot) busy = 1'b0;
            end
        end
    end

    // Reference model and per-cycle protocol checks
    initial begin : mon
        logic [NUM_REQ-1:0] exp_rdy, exp_rv;
        int g, n, d;
        bit done;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                exp_q.delete();
                m_busy = 1'b0; ar_pend = 1'b0; err_exp = 1'b0; m_last = NUM_REQ - 1;
            end else begin
                done = 1'b0;
                // R routing toward the current burst owner
                exp_rv = '0;
                if (exp_q.size() > 0 && bus.m_rvalid) exp_rv[exp_q[0].dest] = 1'b1;
                n_checks++;
                if (bus.s_rvalid !== exp_rv) begin
                    n_fail++;
                    $display("FAIL r_route: s_rvalid=%b expected=%b", bus.s_rvalid, exp_rv);
                end
                if (exp_q.size() > 0 && !ar_pend) begin
                    d = exp_q[0].dest;
                    n_checks++;
                    if (bus.m_rready !== bus.s_rready[d]) begin
                        n_fail++;
                        $display("FAIL m_rready: got=%b expected=%b", bus.m_rready, bus.s_rready[d]);
                    end
                    if (bus.s_rvalid[d] && bus.s_rready[d]) begin
                        n_checks++;
                        if (bus.s_rdata !== exp_q[0].data || bus.s_rlast !== exp_q[0].last) begin
                            n_fail++;
                            $display("FAIL r_beat: data=%h last=%b expected data=%h last=%b",
                                     bus.s_rdata, bus.s_rlast, exp_q[0].data, exp_q[0].last);
                        end
                        last_data  = bus.s_rdata;
                        last_rlast = bus.s_rlast;
                        last_dest  = d;
                        delivered++;
                        done = exp_q[0].last;
                        void'(exp_q.pop_front());
                    end
                end
                // RAM-side AR must be up one cycle after the grant and stay stable
                if (ar_pend) begin
                    n_checks++;
                    if (bus.m_arvalid !== 1'b1 || bus.m_arid !== ar_id ||
                        bus.m_araddr !== ar_addr || bus.m_arlen !== ar_len) begin
                        n_fail++;
                        $display("FAIL m_ar: valid=%b id=%h addr=%h len=%0d expected 1 %h %h %0d",
                                 bus.m_arvalid, bus.m_arid, bus.m_araddr, bus.m_arlen,
                                 ar_id, ar_addr, ar_len);
                    end
                    if (bus.m_arvalid && bus.m_arready) ar_pend = 1'b0;
                end
                // Grant: one burst at a time, chosen by the arbitration rule
                g = m_busy ? -1 : pick(bus.s_arvalid, m_last);
                exp_rdy = '0;
                if (g >= 0) exp_rdy[g] = 1'b1;
                n_checks++;
                if (bus.s_arready !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL grant: s_arready=%b expected=%b", bus.s_arready, exp_rdy);
                end
                if (g >= 0) begin
                    m_busy  = 1'b1;
                    m_last  = g;
                    ar_pend = 1'b1;
                    ar_id   = bus.s_arid[g*IW +: IW];
                    ar_addr = bus.s_araddr[g*AW +: AW];
                    ar_len  = bus.s_arlen[g*8 +: 8];
                    grant_log.push_back(g);
                    n = (inj_tot > 0) ? inj_tot : int'(ar_len) + 1;
                    if (n != int'(ar_len) + 1) err_exp = 1'b1;
                    for (int i = 0; i < n; i++) begin
                        exp_q.push_back('{dest: g,
                                          data: mem[((int'(ar_addr) >> 2) + i) % MEMW],
                                          last: (i == n - 1)});
                    end
                end
                if (done) m_busy = 1'b0;
            end
        end
    end

    task automatic wait_idle(input int max_cyc, output bit ok);
        int c = 0;
        int pend;
        forever begin
            pend = 0;
            for (int k = 0; k < NUM_REQ; k++) pend += req_q[k].size();
            if ((pend == 0 && !m_busy) || c >= max_cyc) break;
            @(negedge clk);
            #2;
            c++;
        end
        ok = (c < max_cyc);
    endtask

    task automatic wait_beats(input int target, input int max_cyc, output bit ok);
        int c = 0;
        while (delivered < target && c < max_cyc) begin
            @(negedge clk);
            #2;
            c++;
        end
        ok = (c < max_cyc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.s_arready !== '0 || bus.s_rvalid !== '0 || bus.m_arvalid !== 1'b0 ||
            bus.m_rready !== 1'b0 || len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: arready=%b rvalid=%b m_arvalid=%b m_rready=%b len_err=%b expected all 0",
                     bus.s_arready, bus.s_rvalid, bus.m_arvalid, bus.m_rready, len_err);
        end
        n_checks++;
        if (bus.m_arid !== '0 || bus.m_araddr !== '0 || bus.m_arlen !== '0 ||
            bus.m_arsize !== 3'd2 || bus.m_arburst !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_ar: id=%h addr=%h len=%h size=%0d burst=%b expected 0 0 0 2 01",
                     bus.m_arid, bus.m_araddr, bus.m_arlen, bus.m_arsize, bus.m_arburst);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_simultaneous();
        int base = grant_log.size();
        bit ok;
        req_q[0].push_back('{id: 8'h11, addr: 16'h0040, len: 8'd3});
        req_q[1].push_back('{id: 8'h22, addr: 16'h0080, len: 8'd2});
        wait_idle(300, ok);
        n_checks++;
        if (!ok || grant_log.size() < base + 2 || grant_log[base] != 0 || grant_log[base+1] != 1) begin
            n_fail++;
            $display("FAIL simultaneous: done=%b grants=%0d first=%0d expected done order 0,1",
                     ok, grant_log.size() - base, (grant_log.size() > base) ? grant_log[base] : -1);
        end
    endtask

    task automatic test_single_beat();
        int start = delivered;
        bit ok;
        mem[4] = 32'hDEADBEEF;
        req_q[1].push_back('{id: 8'h5A, addr: 16'h0010, len: 8'd0});
        wait_idle(200, ok);
        n_checks++;
        if (!ok || delivered != start + 1 || last_data !== 32'hDEADBEEF ||
            last_rlast !== 1'b1 || last_dest != 1) begin
            n_fail++;
            $display("FAIL single_beat: beats=%0d data=%h last=%b dest=%0d expected 1 DEADBEEF 1 1",
                     delivered - start, last_data, last_rlast, last_dest);
        end
    endtask

    task automatic test_stall();
        int start = delivered;
        bit ok, held;
        logic [DW-1:0] hold_data;
        rr_rand = 1'b0;
        held = 1'b0;
        hold_data = '0;
        req_q[0].push_back('{id: 8'h33, addr: 16'h0100, len: 8'd7});
        wait_beats(start + 2, 200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_start: beats=%0d expected at least 2", delivered - start);
        end
        stall_cnt[0] = 5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            n_checks++;
            if (bus.m_rready !== 1'b0 || (held && (bus.m_rvalid !== 1'b1 || bus.m_rdata !== hold_data))) begin
                n_fail++;
                $display("FAIL stall_hold: m_rready=%b m_rvalid=%b data=%h expected 0 with data %h held",
                         bus.m_rready, bus.m_rvalid, bus.m_rdata, hold_data);
            end
            if (!held && bus.m_rvalid) begin
                held = 1'b1;
                hold_data = bus.m_rdata;
            end
        end
        wait_idle(300, ok);
        n_checks++;
        if (!ok || delivered != start + 8) begin
            n_fail++;
            $display("FAIL stall_total: beats=%0d expected 8", delivered - start);
        end
    endtask

    task automatic test_len_err();
        bit ok;
        inj_tot = 3;
        req_q[0].push_back('{id: 8'h44, addr: 16'h0200, len: 8'd4});
        wait_idle(200, ok);
        inj_tot = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (!ok || len_err !== 1'b1 || len_err !== err_exp) begin
            n_fail++;
            $display("FAIL len_err_set: len_err=%b expected 1", len_err);
        end
        req_q[1].push_back('{id: 8'h45, addr: 16'h0220, len: 8'd2});
        wait_idle(200, ok);
        repeat (2) @(negedge clk);
        n_checks++;
        if (!ok || len_err !== 1'b1) begin
            n_fail++;
            $display("FAIL len_err_sticky: len_err=%b expected 1", len_err);
        end
    endtask

    task automatic test_reset_mid();
        int start = delivered;
        int base;
        bit ok;
        rr_rand = 1'b0;
        req_q[0].push_back('{id: 8'h55, addr: 16'h0300, len: 8'd7});
        wait_beats(start + 2, 200, ok);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (!ok || bus.s_rvalid !== '0 || bus.m_arvalid !== 1'b0 ||
            bus.m_rready !== 1'b0 || len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: started=%b rvalid=%b m_arvalid=%b m_rready=%b len_err=%b expected 1 0 0 0 0",
                     ok, bus.s_rvalid, bus.m_arvalid, bus.m_rready, len_err);
        end
        @(negedge clk);
        rst = 1'b0;
        base = grant_log.size();
        start = delivered;
        req_q[1].push_back('{id: 8'h56, addr: 16'h0340, len: 8'd3});
        wait_idle(200, ok);
        n_checks++;
        if (!ok || grant_log.size() != base + 1 || delivered != start + 4 || len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_recover: grants=%0d beats=%0d len_err=%b expected 1 4 0",
                     grant_log.size() - base, delivered - start, len_err);
        end
    endtask

    task automatic test_fairness();
        int base = grant_log.size();
        int pos1 = -1;
        bit ok;
        rr_rand = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_q[0].push_back('{id: 8'(8'h60 + i), addr: 16'($urandom_range(0, 255) * 4),
                                 len: 8'($urandom_range(0, 5))});
        end
        req_q[1].push_back('{id: 8'h77, addr: 16'h0400, len: 8'd2});
        wait_idle(3000, ok);
        for (int i = base; i < grant_log.size(); i++) if (grant_log[i] == 1 && pos1 < 0) pos1 = i - base;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
        n_checks++;
        if (!ok || grant_log.size() != base + 11 || grant_log[base+1] != 0 || pos1 != 10) begin
            n_fail++;
            $display("FAIL fairness: done=%b req1_pos=%0d expected req0 back-to-back, req1 last (10)",
                     ok, pos1);
        end
`else
        n_checks++;
        if (!ok || grant_log.size() != base + 11 || grant_log[base] != 0 || pos1 != 1 ||
            grant_log[base+2] != 0) begin
            n_fail++;
            $display("FAIL fairness: done=%b req1_pos=%0d expected grants 0,1,0 (req1 at 1)", ok, pos1);
        end
`endif
    endtask

    task automatic test_len255();
        int start = delivered;
        bit ok;
        rr_rand = 1'b1;
        req_q[1].push_back('{id: 8'hFF, addr: 16'h0000, len: 8'd255});
        wait_idle(4000, ok);
        repeat (2) @(negedge clk);
        n_checks++;
        if (!ok || delivered != start + 256 || len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL len255: beats=%0d len_err=%b expected 256 0", delivered - start, len_err);
        end
    endtask

    task automatic test_random();
        bit ok;
        rr_rand = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req_q[$urandom_range(0, NUM_REQ - 1)].push_back('{id: 8'($urandom),
                addr: 16'($urandom_range(0, 1023) * 4), len: 8'($urandom_range(0, 15))});
        end
        wait_idle(4000, ok);
        repeat (2) @(negedge clk);
        n_checks++;
        if (!ok || len_err !== err_exp || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random: done=%b len_err=%b expected %b leftover=%0d",
                     ok, len_err, err_exp, exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < MEMW; i++) mem[i] = $urandom;
        for (int k = 0; k < NUM_REQ; k++) stall_cnt[k] = 0;
        test_reset();
        test_simultaneous();
        test_single_beat();
        test_stall();
        test_len_err();
        test_reset_mid();
        test_fairness();
        test_len255();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_ram_rd_arbiter.md
Name: axi_ram_rd_arbiter

Overview:
- N-requester AXI4 read-channel arbiter that shares the single AR/R port of the on-chip AXI RAM between several read masters (DMA, CPU, scrubber).
- Grants one whole burst at a time and routes the R beats back to the granted requester.
- Enforces one outstanding read burst at the RAM.
- Checks beat count against ARLEN and flags mismatches.

Parameters:
- NUM_REQ, 2, number of requesters; valid range 2..8.
- DATA_WIDTH, 32, R data width in bits; must match the RAM.
- ADDR_WIDTH, 16, byte address width.
- ID_WIDTH, 8, ARID width; the requester ID is passed through unchanged.
- STRB_WIDTH, DATA_WIDTH/8, bytes per beat; drives the fixed ARSIZE.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_arid  in  NUM_REQ*ID_WIDTH  per-requester ARID; requester k occupies slice k.
- s_araddr  in  NUM_REQ*ADDR_WIDTH  per-requester start byte address.
- s_arlen  in  NUM_REQ*8  per-requester ARLEN (beats-1).
- s_arvalid  in  NUM_REQ  per-requester AR valid.
- s_arready  out  NUM_REQ  per-requester AR ready; one-hot or zero.
- s_rdata  out  DATA_WIDTH  R data, broadcast to all requesters.
- s_rlast  out  1  R last, broadcast.
- s_rvalid  out  NUM_REQ  R valid, asserted only toward the granted requester.
- s_rready  in  NUM_REQ  per-requester R ready.
- m_arid  out  ID_WIDTH  to RAM.
- m_araddr  out  ADDR_WIDTH  to RAM.
- m_arlen  out  8  to RAM.
- m_arsize  out  3  constant $clog2(STRB_WIDTH).
- m_arburst  out  2  constant 2'b01 (INCR).
- m_arvalid  out  1  to RAM.
- m_arready  in  1  from RAM.
- m_rdata  in  DATA_WIDTH  from RAM.
- m_rlast  in  1  from RAM.
- m_rvalid  in  1  from RAM.
- m_rready  out  1  to RAM.
- len_err  out  1  sticky: beat count did not match ARLEN.

Behaviour:
- States: IDLE, ADDR, DATA.
- Reset values:
  - state=IDLE, rr_ptr=NUM_REQ-1, grant=0, beat_cnt=0, len_err=0.
  - m_arvalid=0, m_arid/m_araddr/m_arlen=0.
  - All s_arready=0, all s_rvalid=0, m_rready=0.
- Reset mid-burst: arbiter drops to IDLE, and remaining R beats are not routed. The RAM shares the same rst, so no stale beats exist.
- IDLE:
  - Grant is combinational over s_arvalid: round-robin search starting at rr_ptr+1 (mod NUM_REQ).
  - s_arready[g]=1 in the same cycle, only while in IDLE and s_arvalid[g]=1.
  - On that handshake, latch id/addr/len of g and grant=g, set beat_cnt=0, go to ADDR.
  - m_arvalid rises the next cycle; grant-to-m_arvalid latency is 1 cycle.
- ADDR:
  - m_arvalid=1 with the latched fields, held stable until m_arready.
  - On m_arvalid&&m_arready: m_arvalid<=0, go to DATA.
- DATA:
  - Routing is combinational: s_rvalid[grant]=m_rvalid, other s_rvalid=0; m_rready=s_rready[grant]; s_rdata=m_rdata; s_rlast=m_rlast.
  - Each m_rvalid&&m_rready beat increments beat_cnt (8-bit, wraps).
  - On the last handshake (m_rlast=1): if beat_cnt != latched len, set len_err=1. Then rr_ptr<=grant and go to IDLE.
  - A new grant is possible the cycle after last, so AR-to-AR spacing is at least 3 cycles.
- Outstanding bursts: no new AR is accepted outside IDLE; s_arready=0 in ADDR and DATA.
- Requester de-asserting s_arvalid before grant: allowed; it is simply not granted.
- Simultaneous requests: exactly one grant per IDLE cycle.
- len_err is cleared only by rst.
- Edge cases:
  - ARLEN=0: single beat with rlast; beat_cnt compares 0==0, no error.
  - ARLEN=255: beat_cnt reaches 255 on last, no error.

Optional Feature:
- Macro: AXI_RD_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is not used or updated.
- Undefined: round-robin as described above.
- All other behaviour is identical.

Test Plan:
- NUM_REQ=2: req0 and req1 both assert in the same cycle with rr_ptr=1 -> req0 granted first, burst of len 3 (4 beats) returned only on s_rvalid[0]; then req1 granted. With macro defined, a back-to-back re-request from req0 wins again.
- Single req1 read, addr 0x0010, len 0, after RAM pre-write 0xDEADBEEF -> one beat 0xDEADBEEF with s_rlast=1 on s_rvalid[1]; m_arvalid asserted 1 cycle after s_arready[1].
- req0 holds s_rready[0]=0 for 5 cycles mid-burst -> m_rready=0 and RAM data held; all 8 beats eventually delivered in order with no loss.
- Inject a slave model that asserts rlast after 3 beats with m_arlen=4 -> len_err=1 and stays set until rst.
- Assert rst during DATA of a len-7 burst -> next cycle: IDLE, all s_rvalid/m_arvalid/m_rready=0, len_err=0; a new request is accepted normally.
- req0 holds s_arvalid continuously while req1 requests once -> grants alternate 0,1,0; no starvation over 10 bursts.
